// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine family: FSM state encoding,
// algorithm selectors and the sizing rule for the Stein shift counter.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    localparam int GCD_SUB   = 0;
    localparam int GCD_STEIN = 1;

    // k counts common factors of two; WIDTH-1 halvings at most, plus headroom.
    function automatic int gcd_k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result valid-ready handshake bundle between a producer/consumer
// (master) and the GCD engine (slave).
interface gcd_engine_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [WIDTH-1:0] out_iters;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_iters, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_iters, out_zero
    );
endinterface

// File: rtl/gcd_step.sv
// One combinational GCD reduction step; the algorithm is fixed at elaboration.
// The caller ignores the next-state outputs whenever eq_o is set.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = GCD_SUB,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             eq_o
);

    assign eq_o = (a_i == b_i);

    generate
        if (ALGO == GCD_STEIN) begin : g_stein
            always_comb begin
                a_o = a_i;
                b_o = b_i;
                k_o = k_i;
                if (!a_i[0] && !b_i[0]) begin
                    a_o = a_i >> 1;
                    b_o = b_i >> 1;
                    k_o = k_i + 1'b1;
                end else if (!a_i[0]) begin
                    a_o = a_i >> 1;
                end else if (!b_i[0]) begin
                    b_o = b_i >> 1;
                end else if (a_i > b_i) begin
                    a_o = a_i - b_i;
                end else begin
                    b_o = b_i - a_i;
                end
            end
        end else begin : g_sub
            always_comb begin
                a_o = a_i;
                b_o = b_i;
                k_o = k_i;
                if (a_i > b_i) begin
                    a_o = a_i - b_i;
                end else begin
                    b_o = b_i - a_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gcd_engine.sv
// GCD accelerator: accepts an operand pair, iterates one gcd_step per cycle,
// then holds the result until the consumer takes it.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ALGO  = GCD_SUB
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);

    localparam int KW = gcd_k_width(WIDTH);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] iters_q, iters_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] a_nx, b_nx;
    logic [KW-1:0]    k_nx;
    logic             eq;

    gcd_step #(
        .WIDTH (WIDTH),
        .ALGO  (ALGO),
        .KW    (KW)
    ) u_step (
        .a_i  (a_q),
        .b_i  (b_q),
        .k_i  (k_q),
        .a_o  (a_nx),
        .b_o  (b_nx),
        .k_o  (k_nx),
        .eq_o (eq)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        iters_d = iters_q;
        gcd_d   = gcd_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    k_d     = '0;
                    iters_d = '0;
                    // A zero operand short-circuits: gcd(x,0) = x, gcd(0,0) = 0.
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        gcd_d   = bus.in_a | bus.in_b;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (eq) begin
                    gcd_d   = a_q << k_q;
                    state_d = S_DONE;
                end else begin
                    a_d = a_nx;
                    b_d = b_nx;
                    k_d = k_nx;
                    if (iters_q != '1) begin
                        iters_d = iters_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            iters_q <= '0;
            gcd_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            iters_q <= iters_d;
            gcd_q   <= gcd_d;
            zero_q  <= zero_d;
        end
    end

    // Handshake outputs come straight from the state register only.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_gcd   = gcd_q;
    assign bus.out_iters = iters_q;
    assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: four instances (16/8-bit, subtractive/Stein) behind a
// shared driver, a directed vector table, corner sequences and random runs.
module tb_gcd_engine;

    typedef struct {
        int unsigned gcd;
        int unsigned iters;
        bit          zero;
        int          lat;
    } exp_t;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int          sel;
        int unsigned gcd;
        int unsigned iters;
        bit          zero;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    int          sel = 0;

    logic        o_valid, o_rdy, o_zero;
    logic [15:0] o_gcd, o_iters;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gcd_engine_if #(.WIDTH(16)) if0 ();
    gcd_engine_if #(.WIDTH(16)) if1 ();
    gcd_engine_if #(.WIDTH(8))  if2 ();
    gcd_engine_if #(.WIDTH(8))  if3 ();

    assign if0.in_valid = in_valid && (sel == 0);
    assign if1.in_valid = in_valid && (sel == 1);
    assign if2.in_valid = in_valid && (sel == 2);
    assign if3.in_valid = in_valid && (sel == 3);
    assign if0.in_a = a_drv;
    assign if0.in_b = b_drv;
    assign if1.in_a = a_drv;
    assign if1.in_b = b_drv;
    assign if2.in_a = a_drv[7:0];
    assign if2.in_b = b_drv[7:0];
    assign if3.in_a = a_drv[7:0];
    assign if3.in_b = b_drv[7:0];
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;
    assign if3.out_ready = out_ready;

    gcd_engine #(.WIDTH(16), .ALGO(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    gcd_engine #(.WIDTH(16), .ALGO(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    gcd_engine #(.WIDTH(8),  .ALGO(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
    gcd_engine #(.WIDTH(8),  .ALGO(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

    always_comb begin
        o_valid = if0.out_valid;
        o_rdy   = if0.in_ready;
        o_gcd   = if0.out_gcd;
        o_iters = if0.out_iters;
        o_zero  = if0.out_zero;
        case (sel)
            1: begin
                o_valid = if1.out_valid; o_rdy = if1.in_ready; o_gcd = if1.out_gcd;
                o_iters = if1.out_iters; o_zero = if1.out_zero;
            end
            2: begin
                o_valid = if2.out_valid; o_rdy = if2.in_ready; o_gcd = {8'h00, if2.out_gcd};
                o_iters = {8'h00, if2.out_iters}; o_zero = if2.out_zero;
            end
            3: begin
                o_valid = if3.out_valid; o_rdy = if3.in_ready; o_gcd = {8'h00, if3.out_gcd};
                o_iters = {8'h00, if3.out_iters}; o_zero = if3.out_zero;
            end
            default: ;
        endcase
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Step-count model: walks the algorithm's reduction rules; the result
    // value itself comes from the independent modulo-based reference.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int s);
        exp_t e;
        int unsigned x = a, y = b, cnt = 0;
        int unsigned mask = (s < 2) ? 32'hFFFF : 32'hFF;
        bit stein = (s % 2) == 1;
        if (a == 0 || b == 0) begin
            e.gcd = a | b; e.iters = 0; e.zero = 1'b1; e.lat = 1;
            return e;
        end
        while (x != y) begin
            if (stein && x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
            else if (stein && x % 2 == 0) x = x / 2;
            else if (stein && y % 2 == 0) y = y / 2;
            else if (x > y) x = x - y;
            else y = y - x;
            cnt++;
        end
        e.gcd = ref_gcd(a, b);
        e.iters = (cnt > mask) ? mask : cnt;
        e.zero = 1'b0;
        e.lat = cnt + 2;
        return e;
    endfunction

    task automatic send(input int unsigned a, input int unsigned b, input exp_t e);
        int j = 0;
        a_drv = a[15:0];
        b_drv = b[15:0];
        in_valid = 1'b1;
        while (!o_rdy && j < 100) begin
            @(negedge clk);
            j++;
        end
        if (!o_rdy) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic recv(input int limit);
        exp_t e;
        int j = 0;
        @(negedge clk);
        while (!o_valid && j < limit) begin
            @(negedge clk);
            j++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        if (!o_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("gcd", o_gcd, e.gcd);
        check("iters", o_iters, e.iters);
        check("zero", o_zero, e.zero);
        check("latency", j + 1, e.lat);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_take", o_rdy, 1);
    endtask

    vec_t tbl[9];
    exp_t e;

    initial begin
        tbl[0] = '{48, 18, 0, 6, 4, 1'b0, 6};
        tbl[1] = '{12, 12, 0, 12, 0, 1'b0, 2};
        tbl[2] = '{1, 65535, 0, 1, 65534, 1'b0, 65536};
        tbl[3] = '{0, 35, 0, 35, 0, 1'b1, 1};
        tbl[4] = '{48, 18, 1, 6, 6, 1'b0, 8};
        tbl[5] = '{0, 0, 1, 0, 0, 1'b1, 1};
        tbl[6] = '{0, 35, 1, 35, 0, 1'b1, 1};
        tbl[7] = '{21, 14, 1, 7, 3, 1'b0, 5};
        tbl[8] = '{35, 0, 1, 35, 0, 1'b1, 1};

        #3;
        check("rst_in_ready", o_rdy, 1);
        check("rst_out_valid", o_valid, 0);
        check("rst_out_gcd", o_gcd, 0);
        check("rst_out_iters", o_iters, 0);
        check("rst_out_zero", o_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            e.gcd = tbl[i].gcd; e.iters = tbl[i].iters; e.zero = tbl[i].zero; e.lat = tbl[i].lat;
            send(tbl[i].a, tbl[i].b, e);
            recv(70000);
        end

        // Backpressure: result must hold and new operands must be ignored.
        sel = 0;
        out_ready = 1'b0;
        send(48, 18, model(48, 18, 0));
        begin
            int j = 0;
            @(negedge clk);
            while (!o_valid && j < 100) begin
                @(negedge clk);
                j++;
            end
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a_drv = 16'd5; b_drv = 16'd5; in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            check("bp_valid", o_valid, 1);
            check("bp_gcd", o_gcd, e.gcd);
            check("bp_iters", o_iters, e.iters);
            check("bp_in_ready", o_rdy, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", o_rdy, 1);
        check("bp_release_valid", o_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_pulse_ignored", o_valid, 0);
        end

        // Reset in the middle of a long subtractive run.
        send(1000, 3, model(1000, 3, 0));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_calc_valid", o_valid, 0);
        check("rst_calc_in_ready", o_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        send(21, 14, model(21, 14, 0));
        recv(100);

        // Reset while a result is waiting in DONE.
        out_ready = 1'b0;
        send(0, 5, model(0, 5, 0));
        @(negedge clk);
        check("done_before_rst", o_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_done_valid", o_valid, 0);
        check("rst_done_in_ready", o_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        @(negedge clk);

        // Random regression on the 8-bit instances, both algorithms.
        for (int s = 2; s < 4; s++) begin
            sel = s;
            for (int n = 0; n < 30; n++) begin
                int unsigned ra, rb;
                ra = (n % 10 == 7) ? 0 : $urandom_range(0, 255);
                rb = (n % 10 == 4) ? 0 : $urandom_range(1, 255);
                send(ra, rb, model(ra, rb, s));
                recv(1000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
